// File: rtl/seg7_pattern_decoder_if.sv
// Segment-bus bundle between a HEX pattern source and seg7_pattern_decoder.
// err_count exists only when SEG7_ERR_COUNT_EN is defined.
interface seg7_pattern_decoder_if #(
  parameter int CNT_W = 8
);
  typedef logic [CNT_W-1:0] err_t;

  logic [7:0] seg_in;
  logic       sample_en;
  logic [3:0] value;
  logic       dp;
  logic       valid;
  logic       update;
  logic       invalid;

`ifdef SEG7_ERR_COUNT_EN
  err_t       err_count;

  modport master (
    output seg_in, sample_en,
    input  value, dp, valid, update, invalid, err_count
  );

  modport slave (
    input  seg_in, sample_en,
    output value, dp, valid, update, invalid, err_count
  );
`else
  modport master (
    output seg_in, sample_en,
    input  value, dp, valid, update, invalid
  );

  modport slave (
    input  seg_in, sample_en,
    output value, dp, valid, update, invalid
  );
`endif

endinterface

// File: rtl/seg7_pattern_decoder.sv
// Debounces an active-low 7-segment pattern and decodes it back to a hex digit + DP.
// Optional saturating invalid-lock counter enabled by defining SEG7_ERR_COUNT_EN.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic                  clk,
  input logic                  reset,
  seg7_pattern_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2,
    BAD    = 2'd3
  } state_t;

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK      = 7'h7F;

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || CNT_W < 1) begin : g_param_check
    $error("seg7_pattern_decoder: STABLE_CYCLES must be 1..255 and CNT_W >= 1");
  end

  // Returns {hit, digit}; hit is low for anything outside the hex table.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] stab_cnt_q, stab_cnt_d;
  logic [3:0] value_q, value_d;
  logic       dp_q, dp_d;
  logic       valid_q, valid_d;
  logic       update_q, update_d;
  logic       invalid_q, invalid_d;
  logic       lock_en;
  logic [4:0] dec;

`ifdef SEG7_ERR_COUNT_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;
`endif

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    value_d    = value_q;
    dp_d       = dp_q;
    valid_d    = valid_q;
    update_d   = 1'b0;
    invalid_d  = invalid_q;
    lock_en    = 1'b0;
`ifdef SEG7_ERR_COUNT_EN
    err_count_d = err_count_q;
`endif

    // A change always restarts the count, so it takes priority over a lock in SETTLE.
    if (bus.sample_en) begin
      if (bus.seg_in != cand_q) begin
        cand_d     = bus.seg_in;
        stab_cnt_d = 8'd1;
        state_d    = SETTLE;
        valid_d    = 1'b0;
        invalid_d  = 1'b0;
        lock_en    = (STABLE_LIM == 8'd1);
      end else if (state_q == SETTLE) begin
        stab_cnt_d = stab_cnt_q + 8'd1;
        lock_en    = (stab_cnt_d == STABLE_LIM);
      end
    end

    dec = decode(cand_d[6:0]);

    if (lock_en) begin
      if (cand_d[6:0] == BLANK) begin
        state_d = IDLE;
      end else if (dec[4]) begin
        state_d  = LOCKED;
        value_d  = dec[3:0];
        dp_d     = ~cand_d[7];
        valid_d  = 1'b1;
        update_d = 1'b1;
      end else begin
        state_d   = BAD;
        invalid_d = 1'b1;
`ifdef SEG7_ERR_COUNT_EN
        if (err_count_q != {CNT_W{1'b1}}) begin
          err_count_d = err_count_q + 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cand_q      <= 8'hFF;
      stab_cnt_q  <= 8'd0;
      value_q     <= 4'h0;
      dp_q        <= 1'b0;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
      invalid_q   <= 1'b0;
`ifdef SEG7_ERR_COUNT_EN
      err_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      stab_cnt_q  <= stab_cnt_d;
      value_q     <= value_d;
      dp_q        <= dp_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
      invalid_q   <= invalid_d;
`ifdef SEG7_ERR_COUNT_EN
      err_count_q <= err_count_d;
`endif
    end
  end

  assign bus.value   = value_q;
  assign bus.dp      = dp_q;
  assign bus.valid   = valid_q;
  assign bus.update  = update_q;
  assign bus.invalid = invalid_q;
`ifdef SEG7_ERR_COUNT_EN
  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Self-checking bench for seg7_pattern_decoder: two DUTs (STABLE_CYCLES 4 and 1)
// share one stimulus stream and are checked against a run-length reference model.
module tb_seg7_pattern_decoder;

  localparam int CNT_W   = 8;
  localparam int ERR_MAX = (1 << CNT_W) - 1;
  localparam int RUN_SAT = 100000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg_in;
  logic       sample_en;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  seg7_pattern_decoder_if #(.CNT_W(CNT_W)) bus_a ();
  seg7_pattern_decoder_if #(.CNT_W(CNT_W)) bus_b ();

  assign bus_a.seg_in    = seg_in;
  assign bus_a.sample_en = sample_en;
  assign bus_b.seg_in    = seg_in;
  assign bus_b.sample_en = sample_en;

  seg7_pattern_decoder #(.STABLE_CYCLES(4), .CNT_W(CNT_W)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  seg7_pattern_decoder #(.STABLE_CYCLES(1), .CNT_W(CNT_W)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Reference model: a lock happens when the run of identical samples reaches exactly N.
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         stab [2] = '{4, 1};
  logic [7:0] m_last  [2];
  int         m_run   [2];
  logic       m_upd   [2];
  logic       m_val   [2];
  logic       m_inv   [2];
  logic       m_dp    [2];
  logic [3:0] m_value [2];
  int         m_err   [2];

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i] == s) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k]  = 8'hFF;
      m_run[k]   = RUN_SAT;
      m_upd[k]   = 1'b0;
      m_val[k]   = 1'b0;
      m_inv[k]   = 1'b0;
      m_dp[k]    = 1'b0;
      m_value[k] = 4'h0;
      m_err[k]   = 0;
    end
  endtask

  task automatic model_sample(input logic [7:0] s, input logic en);
    int idx;
    for (int k = 0; k < 2; k++) begin
      m_upd[k] = 1'b0;
      if (en) begin
        if (s != m_last[k]) begin
          m_last[k] = s;
          m_run[k]  = 1;
          m_val[k]  = 1'b0;
          m_inv[k]  = 1'b0;
        end else if (m_run[k] < RUN_SAT) begin
          m_run[k]++;
        end
        if (m_run[k] == stab[k]) begin
          idx = lookup(s[6:0]);
          if (s[6:0] == 7'h7F) begin
            // blank: quiet lock
          end else if (idx >= 0) begin
            m_value[k] = 4'(idx);
            m_dp[k]    = ~s[7];
            m_val[k]   = 1'b1;
            m_upd[k]   = 1'b1;
          end else begin
            m_inv[k] = 1'b1;
            if (m_err[k] < ERR_MAX) m_err[k]++;
          end
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_obs(input int k);
    logic [7:0] e;
`ifdef SEG7_ERR_COUNT_EN
    e = 8'(m_err[k]);
`else
    e = 8'h00;
`endif
    return {m_upd[k], m_val[k], m_inv[k], m_value[k], m_dp[k], e};
  endfunction

  function automatic logic [15:0] dut_obs(input int k);
    logic [7:0] e;
    if (k == 0) begin
`ifdef SEG7_ERR_COUNT_EN
      e = 8'(bus_a.err_count);
`else
      e = 8'h00;
`endif
      return {bus_a.update, bus_a.valid, bus_a.invalid, bus_a.value, bus_a.dp, e};
    end
`ifdef SEG7_ERR_COUNT_EN
    e = 8'(bus_b.err_count);
`else
    e = 8'h00;
`endif
    return {bus_b.update, bus_b.valid, bus_b.invalid, bus_b.value, bus_b.dp, e};
  endfunction

  // Drive one sample, update the model at the edge, return at the following negedge.
  task automatic step(input logic [7:0] s, input logic en);
    seg_in    = s;
    sample_en = en;
    @(posedge clk);
    model_sample(s, en);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    seg_in    = 8'hFF;
    sample_en = 1'b0;
    reset     = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (dut_obs(k) !== 16'h0000) begin
        failed++;
        $display("[TB] FAIL reset_state[%0d]: got %h, want 0000", k, dut_obs(k));
      end
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_hold_lock();
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(8'hC0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (dut_obs(k) !== exp_obs(k)) begin
          failed++;
          $display("[TB] FAIL hold_lock[%0d] i=%0d: got %h, want %h", k, i, dut_obs(k), exp_obs(k));
        end
      end
      if (bus_a.update === 1'b1) pulses++;
      if (i == 3) begin
        compared++;
        if ({bus_a.update, bus_a.valid, bus_a.value, bus_a.dp} !== 7'b11_0000_0) begin
          failed++;
          $display("[TB] FAIL hold_lock_4th: got %b, want 1100000",
                   {bus_a.update, bus_a.valid, bus_a.value, bus_a.dp});
        end
      end
    end
    compared++;
    if (pulses != 1) begin
      failed++;
      $display("[TB] FAIL hold_lock_pulses: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_step_sequence();
    logic [7:0] pats [4] = '{8'hF9, 8'h24, 8'h30, 8'h99};
    int pulses = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 6; i++) begin
        step(pats[p], 1'b1);
        for (int k = 0; k < 2; k++) begin
          compared++;
          if (dut_obs(k) !== exp_obs(k)) begin
            failed++;
            $display("[TB] FAIL step_seq[%0d] p=%0d i=%0d: got %h, want %h", k, p, i, dut_obs(k), exp_obs(k));
          end
        end
        if (bus_a.update === 1'b1) begin
          pulses++;
          compared++;
          if (bus_a.value !== 4'(p + 1) || i != 3) begin
            failed++;
            $display("[TB] FAIL step_seq_value: got %h at i=%0d, want %h at i=3", bus_a.value, i, p + 1);
          end
        end
      end
    end
    compared++;
    if (pulses != 4) begin
      failed++;
      $display("[TB] FAIL step_seq_pulses: got %0d, want 4", pulses);
    end
  endtask

  task automatic test_dp_blank();
    for (int i = 0; i < 12; i++) begin
      step((i < 6) ? 8'h00 : 8'hFF, 1'b1);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (dut_obs(k) !== exp_obs(k)) begin
          failed++;
          $display("[TB] FAIL dp_blank[%0d] i=%0d: got %h, want %h", k, i, dut_obs(k), exp_obs(k));
        end
      end
      if (i == 5) begin
        compared++;
        if ({bus_a.valid, bus_a.value, bus_a.dp} !== 6'b1_1000_1) begin
          failed++;
          $display("[TB] FAIL dp_lock: got %b, want 110001", {bus_a.valid, bus_a.value, bus_a.dp});
        end
      end
      if (i == 11) begin
        compared++;
        if ({bus_a.valid, bus_a.update, bus_a.invalid} !== 3'b000) begin
          failed++;
          $display("[TB] FAIL blank_lock: got %b, want 000", {bus_a.valid, bus_a.update, bus_a.invalid});
        end
      end
    end
  endtask

  task automatic test_invalid_saturation();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 8; i++) begin
        step((i < 4) ? 8'hAA : 8'hFF, 1'b1);
        for (int k = 0; k < 2; k++) begin
          compared++;
          if (dut_obs(k) !== exp_obs(k)) begin
            failed++;
            $display("[TB] FAIL invalid_sat[%0d] n=%0d i=%0d: got %h, want %h", k, n, i, dut_obs(k), exp_obs(k));
          end
        end
        if (i == 3) begin
          compared++;
          if (bus_a.invalid !== 1'b1 || bus_a.valid !== 1'b0) begin
            failed++;
            $display("[TB] FAIL invalid_flag n=%0d: got inv=%b valid=%b, want inv=1 valid=0", n, bus_a.invalid, bus_a.valid);
          end
        end
      end
    end
`ifdef SEG7_ERR_COUNT_EN
    compared++;
    if (bus_a.err_count !== 8'd255) begin
      failed++;
      $display("[TB] FAIL err_saturate: got %0d, want 255", bus_a.err_count);
    end
`endif
  endtask

  task automatic test_glitch_gap();
    logic [7:0] pre [4] = '{8'h92, 8'h92, 8'hC0, 8'hC0};
    for (int i = 0; i < 4; i++) begin
      step(pre[i], 1'b1);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (dut_obs(k) !== exp_obs(k)) begin
          failed++;
          $display("[TB] FAIL glitch[%0d] i=%0d: got %h, want %h", k, i, dut_obs(k), exp_obs(k));
        end
      end
      compared++;
      if (bus_a.update !== 1'b0) begin
        failed++;
        $display("[TB] FAIL glitch_no_update i=%0d: got 1, want 0", i);
      end
    end
    // fresh 92: two samples, a 10-cycle gap, then two more samples complete the lock
    for (int s = 1; s <= 16; s++) begin
      step(8'h92, (s >= 3 && s <= 12) ? 1'b0 : 1'b1);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (dut_obs(k) !== exp_obs(k)) begin
          failed++;
          $display("[TB] FAIL gap[%0d] s=%0d: got %h, want %h", k, s, dut_obs(k), exp_obs(k));
        end
      end
      compared++;
      if (bus_a.update !== ((s == 14) ? 1'b1 : 1'b0)) begin
        failed++;
        $display("[TB] FAIL gap_timing s=%0d: got update=%b, want %b", s, bus_a.update, s == 14);
      end
    end
  endtask

  task automatic test_reset_mid_settle();
    for (int i = 0; i < 3; i++) step(8'h19, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (dut_obs(k) !== 16'h0000) begin
        failed++;
        $display("[TB] FAIL mid_settle_reset[%0d]: got %h, want 0000", k, dut_obs(k));
      end
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step((i < 6) ? 8'h19 : 8'hFF, (i < 6) ? 1'b0 : 1'b1);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (dut_obs(k) !== exp_obs(k)) begin
          failed++;
          $display("[TB] FAIL after_reset[%0d] i=%0d: got %h, want %h", k, i, dut_obs(k), exp_obs(k));
        end
      end
      compared++;
      if (bus_a.update !== 1'b0) begin
        failed++;
        $display("[TB] FAIL after_reset_update i=%0d: got 1, want 0", i);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pat;
    int         len;
    int         sel;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      pat = {1'($urandom_range(0, 1)), tbl[$urandom_range(0, 15)]};
      else if (sel < 8) pat = {1'($urandom_range(0, 1)), 7'h7F};
      else              pat = 8'($urandom_range(0, 255));
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        step(pat, ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
        for (int k = 0; k < 2; k++) begin
          compared++;
          if (dut_obs(k) !== exp_obs(k)) begin
            failed++;
            $display("[TB] FAIL random[%0d] n=%0d pat=%h: got %h, want %h", k, n, pat, dut_obs(k), exp_obs(k));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_lock();
    test_step_sequence();
    test_dp_blank();
    test_invalid_saturation();
    test_glitch_gap();
    test_reset_mid_settle();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
